// File: rtl/wb_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sel_arbiter
//  Purpose  : Round-robin arbiter for a shared 5-bit 4:1 write-back select mux,
//             with multi-cycle ownership, end-of-transfer release and a
//             hold-limit watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_sel_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_hold_max = CW'(HOLD_MAX);
    localparam logic [CW-1:0] c_hold_one = CW'(1);

    state_t        r_state,    w_state_nxt;
    logic [3:0]    r_gnt,      w_gnt_nxt;
    logic [1:0]    r_sel,      w_sel_nxt;
    logic [1:0]    r_rr_ptr,   w_rr_ptr_nxt;
    logic [CW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic          r_timeout,  w_timeout_nxt;

    logic [3:0]    w_req_m;
    logic          w_win_vld;
    logic [1:0]    w_win_idx;
    logic          w_own_req;
    logic          w_own_last;
    logic          w_at_limit;
    logic          w_release;

    // The current owner is excluded from the search that decides its successor.
    assign w_req_m    = (r_state == S_GRANT) ? (req & ~r_gnt) : req;
    assign w_own_req  = |(req  & r_gnt);
    assign w_own_last = |(last & r_gnt);
    assign w_at_limit = (r_hold_cnt == c_hold_max);
    assign w_release  = (w_own_last & w_own_req) | ~w_own_req | w_at_limit;

    // Search rr_ptr+1 .. rr_ptr+4; iterating downward leaves the nearest hit.
    always_comb begin
        logic [1:0] w_cand;
        w_win_vld = 1'b0;
        w_win_idx = 2'b00;
        w_cand    = 2'b00;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_rr_ptr + 2'(k);
            if (w_req_m[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_sel_nxt      = r_sel;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt    = S_GRANT;
                    w_gnt_nxt      = 4'b0001 << w_win_idx;
                    w_sel_nxt      = w_win_idx;
                    w_rr_ptr_nxt   = w_win_idx;
                    w_hold_cnt_nxt = c_hold_one;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    // Watchdog only blames an owner still requesting without last.
                    w_timeout_nxt = w_own_req & ~w_own_last & w_at_limit;
                    if (w_win_vld) begin
                        w_gnt_nxt      = 4'b0001 << w_win_idx;
                        w_sel_nxt      = w_win_idx;
                        w_rr_ptr_nxt   = w_win_idx;
                        w_hold_cnt_nxt = c_hold_one;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_gnt_nxt      = 4'b0000;
                        w_hold_cnt_nxt = '0;
                    end
                end else if (r_hold_cnt != '1) begin
                    w_hold_cnt_nxt = r_hold_cnt + c_hold_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'b00;
            r_rr_ptr   <= 2'd3;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign busy    = (r_state == S_GRANT);
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_sel_arbiter
//  Purpose  : Directed self-checking bench for wb_sel_arbiter (HOLD_MAX=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks;
    int failures;

    wb_sel_arbiter #(
        .HOLD_MAX(4),
        .CW      (8)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .last   (last),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;
        tick();
        checks++;
        if ({gnt, sel, busy, timeout} !== 8'b0000_00_0_0) begin
            failures++;
            $display("FAIL reset: gnt=%b sel=%0d busy=%b timeout=%b expected 0000/0/0/0",
                     gnt, sel, busy, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0000_0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b busy=%b expected 0000/0", gnt, busy);
        end
    endtask

    task automatic test_single_transfer();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if ({gnt, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL single_grant: gnt=%b sel=%0d busy=%b expected 0100/2/1", gnt, sel, busy);
        end
        tick();
        tick();
        last = 4'b0100;
        tick();
        checks++;
        if ({gnt, busy, sel} !== {4'b0000, 1'b0, 2'd2}) begin
            failures++;
            $display("FAIL single_release: gnt=%b busy=%b sel=%0d expected 0000/0/2", gnt, busy, sel);
        end
        req  = 4'b0000;
        last = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            last    = 4'b0000;
            exp_gnt = 4'b0001 << order[i];
            checks++;
            if ({gnt, sel, busy} !== {exp_gnt, 2'(order[i]), 1'b1}) begin
                failures++;
                $display("FAIL rr_order[%0d]: gnt=%b sel=%0d busy=%b expected %b/%0d/1",
                         i, gnt, sel, busy, exp_gnt, order[i]);
            end
            tick();
            checks++;
            if (gnt !== exp_gnt) begin
                failures++;
                $display("FAIL rr_hold[%0d]: gnt=%b expected %b", i, gnt, exp_gnt);
            end
            last = exp_gnt;
        end
        req = 4'b0000;
        tick();
        last = 4'b0000;
        checks++;
        if ({gnt, busy} !== 5'b0000_0) begin
            failures++;
            $display("FAIL rr_end: gnt=%b busy=%b expected 0000/0", gnt, busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({gnt, timeout} !== {4'b0001, 1'b0}) begin
                failures++;
                $display("FAIL wd_hold[%0d]: gnt=%b timeout=%b expected 0001/0", i, gnt, timeout);
            end
        end
        tick();
        checks++;
        if ({gnt, busy, timeout} !== {4'b0000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL wd_force: gnt=%b busy=%b timeout=%b expected 0000/0/1", gnt, busy, timeout);
        end
        tick();
        checks++;
        if ({gnt, timeout} !== {4'b0001, 1'b0}) begin
            failures++;
            $display("FAIL wd_regrant: gnt=%b timeout=%b expected 0001/0", gnt, timeout);
        end
        req = 4'b0000;
    endtask

    task automatic test_last_at_limit();
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        last = 4'b0001;
        tick();
        last = 4'b0000;
        checks++;
        if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL last_at_limit: gnt=%b timeout=%b expected 0000/0", gnt, timeout);
        end
        req = 4'b0000;
    endtask

    task automatic test_abandon();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, sel} !== {4'b0010, 2'd1}) begin
            failures++;
            $display("FAIL abandon_grant: gnt=%b sel=%0d expected 0010/1", gnt, sel);
        end
        req = 4'b1000;
        tick();
        checks++;
        if ({gnt, sel, timeout, busy} !== {4'b1000, 2'd3, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abandon_handoff: gnt=%b sel=%0d timeout=%b busy=%b expected 1000/3/0/1",
                     gnt, sel, timeout, busy);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL abandon_idle: gnt=%b timeout=%b expected 0000/0", gnt, timeout);
        end
    endtask

    task automatic test_nonowner_last();
        do_reset();
        req = 4'b0011;
        tick();
        last = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL nonowner_last: gnt=%b expected 0001", gnt);
        end
        last = 4'b0000;
        req  = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0001;
        tick();
        last = 4'b0001;
        tick();
        last = 4'b0000;
        checks++;
        if ({gnt, busy} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL solo_gap: gnt=%b busy=%b expected 0000/0", gnt, busy);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL solo_regrant: gnt=%b expected 0001", gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, sel} !== {4'b0000, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL async_reset: gnt=%b busy=%b sel=%0d expected 0000/0/0", gnt, busy, sel);
        end
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL async_ptr: gnt=%b expected 0001", gnt);
        end
        req = 4'b0000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        last     = 4'b0000;
        test_reset();
        test_single_transfer();
        test_round_robin();
        test_timeout();
        test_last_at_limit();
        test_abandon();
        test_nonowner_last();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
